seg_mux_display: RTL and testbench

Time-multiplexed driver for a NUM_DIGITS common-anode 7-segment display, parametrised in digit count and refresh rate.
- Decodes each 4-bit nibble to an active-low hex glyph.
- Scans the digits with a prescaled refresh counter.
- Adds per-slot anti-ghosting guard time, leading-zero blanking and per-digit decimal points.
- Updates the display tear-free through a shadow register that is applied only at frame boundaries.
- Sits between the datapath's hex/BCD value and the board's seg/anode pins.

---
 rtl/seg_mux_display_pkg.sv | 18 +
 rtl/hex7seg_decode.sv | 12 +
 rtl/seg_mux_display.sv | 135 +++++++++++++
 tb/tb_seg_mux_display.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_mux_display_pkg.sv
// rtl/seg_mux_display_pkg.sv - shared constants and helpers for the 7-segment display driver
package seg_mux_display_pkg;

    // All segments dark (active-low)
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low hex glyphs, bit i drives segment i (a..g), indexed by nibble value
    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Counter width for a modulus of n (never narrower than one bit)
    function automatic int bits_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hex7seg_decode.sv
// rtl/hex7seg_decode.sv - nibble to active-low 7-segment glyph lookup
module hex7seg_decode
    import seg_mux_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Pure table lookup, no blanking here
    assign seg = GLYPH_TABLE[nibble];

endmodule

// File: rtl/seg_mux_display.sv
// rtl/seg_mux_display.sv - time-multiplexed common-anode 7-segment display driver
module seg_mux_display
    import seg_mux_display_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    load,
    input  logic                    enable,
    input  logic                    lz_en,
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int CNT_W = bits_for(REFRESH_DIV);
    localparam int IDX_W = bits_for(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]          cnt;
    logic [IDX_W-1:0]          idx;
    logic                      tick;
    logic                      wrap;
    logic                      wrap_d;
    logic [4*NUM_DIGITS-1:0]   shadow_val;
    logic [NUM_DIGITS-1:0]     shadow_dp;
    logic [4*NUM_DIGITS-1:0]   disp_val;
    logic [NUM_DIGITS-1:0]     disp_dp;
    logic                      pending;
    logic [NUM_DIGITS-1:0]     zero_from;
    logic                      zero_above;
    logic [NUM_DIGITS-1:0]     an_sel;
    logic [3:0]                nibble;
    logic                      dp_sel;
    logic                      blank;
    logic                      in_guard;
    logic [6:0]                glyph_raw;

    assign tick     = (cnt == CNT_LAST);
    assign wrap     = tick && (idx == IDX_LAST);
    assign in_guard = (GUARD > 0) && (cnt < CNT_GUARD);

    // Free-running slot prescaler and digit index; enable never stalls them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick) begin
            cnt <= '0;
            idx <= wrap ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Shadow capture; display only changes at a frame wrap (load on the wrap bypasses the shadow)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_val <= '0;
            shadow_dp  <= '0;
            disp_val   <= '0;
            disp_dp    <= '0;
            pending    <= 1'b0;
        end else begin
            if (load) begin
                shadow_val <= value;
                shadow_dp  <= dp;
            end
            if (load && wrap) begin
                disp_val <= value;
                disp_dp  <= dp;
                pending  <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end else if (wrap && pending) begin
                disp_val <= shadow_val;
                disp_dp  <= shadow_dp;
                pending  <= 1'b0;
            end
        end
    end

    // Digit select, nibble/dp mux and leading-zero detection for the current slot
    always_comb begin
        zero_above = 1'b1;
        zero_from  = '0;
        an_sel     = '0;
        nibble     = 4'h0;
        dp_sel     = 1'b0;
        blank      = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above   = zero_above && (disp_val[4*i +: 4] == 4'h0);
            zero_from[i] = zero_above;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                an_sel[i] = 1'b1;
                nibble    = disp_val[4*i +: 4];
                dp_sel    = disp_dp[i];
                blank     = lz_en && (i != 0) && zero_from[i];
            end
        end
    end

    hex7seg_decode u_decode (
        .nibble (nibble),
        .seg    (glyph_raw)
    );

    // Registered pin drivers; frame_done is delayed so it lines up with digit 0's first output cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= '1;
            seg        <= SEG_BLANK;
            dp_n       <= 1'b1;
            wrap_d     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            an         <= (enable && !in_guard) ? ~an_sel : '1;
            seg        <= (enable && !blank) ? glyph_raw : SEG_BLANK;
            dp_n       <= ~(enable & dp_sel);
            wrap_d     <= wrap;
            frame_done <= wrap_d;
        end
    end

endmodule

// File: tb/tb_seg_mux_display.sv
// tb/tb_seg_mux_display.sv - self-checking bench for seg_mux_display
module tb_seg_mux_display;

    localparam int N = 4;
    localparam int R = 4;
    localparam int G = 1;
    localparam logic [6:0] GL [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp;
        logic        lz;
        int          digit;
        logic [6:0]  seg;
        logic        dpn;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp = '0;
    logic        load = 1'b0;
    logic        enable = 1'b0;
    logic        lz_en = 1'b0;
    logic [6:0]  seg;
    logic        dp_n;
    logic [3:0]  an;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    seg_mux_display #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (R),
        .GUARD       (G)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .dp         (dp),
        .load       (load),
        .enable     (enable),
        .lz_en      (lz_en),
        .seg        (seg),
        .dp_n       (dp_n),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: position in the scan from elapsed cycles, display = latest load seen at a frame start
    int          m_t;
    int          mc;
    int          md;
    int          m_nib;
    bit          m_wrap;
    bit          m_blank;
    bit          m_have;
    logic [15:0] m_disp;
    logic [3:0]  m_ddp;
    logic [15:0] m_latest;
    logic [3:0]  m_ldp;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dpn;
    logic        e_fd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t = 0; m_have = 0; m_disp = '0; m_ddp = '0; m_latest = '0; m_ldp = '0;
            e_an = 4'hF; e_seg = 7'h7F; e_dpn = 1'b1; e_fd = 1'b0;
        end else begin
            mc      = m_t % R;
            md      = (m_t / R) % N;
            m_wrap  = (mc == R - 1) && (md == N - 1);
            m_nib   = int'((m_disp >> (4 * md)) & 16'h000F);
            m_blank = lz_en && (md > 0) && ((m_disp >> (4 * md)) == 16'h0000);
            e_an    = (enable && mc >= G) ? ~(4'b0001 << md) : 4'hF;
            e_seg   = (enable && !m_blank) ? GL[m_nib] : 7'h7F;
            e_dpn   = !(enable && m_ddp[md]);
            e_fd    = (mc == 0) && (md == 0) && (m_t >= N * R);
            if (load) begin
                m_latest = value; m_ldp = dp; m_have = 1;
            end
            if (m_wrap && m_have) begin
                m_disp = m_latest; m_ddp = m_ldp; m_have = 0;
            end
            m_t++;
        end
    end

    // Every cycle: DUT against model, plus the single-active-anode rule
    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_an", an, e_an);
            chk("model_seg", seg, e_seg);
            chk("model_dpn", dp_n, e_dpn);
            chk("model_fd", frame_done, e_fd);
            chk("an_onecold", ($countones(~an) <= 1), 1);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_fd(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < 64);
        if (frame_done !== 1'b1) chk(name, frame_done, 1);
    endtask

    task automatic wait_an(input int d);
        logic [3:0] t;
        int n = 0;
        t = ~(4'b0001 << d);
        do begin
            @(negedge clk);
            n++;
        end while (an !== t && n < 64);
        if (an !== t) chk("wait_an_timeout", an, t);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value = v;
        dp    = d;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    vec_t       vecs[$];
    logic [6:0] scan_seg [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};
    logic [3:0] ea;
    int         cnt_p;

    initial begin
        vecs.push_back('{16'h12AF, 4'h0, 1'b0, 0, 7'h0E, 1'b1});
        vecs.push_back('{16'h12AF, 4'h0, 1'b0, 1, 7'h08, 1'b1});
        vecs.push_back('{16'h12AF, 4'h0, 1'b0, 2, 7'h24, 1'b1});
        vecs.push_back('{16'h12AF, 4'h0, 1'b0, 3, 7'h79, 1'b1});
        vecs.push_back('{16'h0050, 4'h8, 1'b1, 0, 7'h40, 1'b1});
        vecs.push_back('{16'h0050, 4'h8, 1'b1, 1, 7'h12, 1'b1});
        vecs.push_back('{16'h0050, 4'h8, 1'b1, 2, 7'h7F, 1'b1});
        vecs.push_back('{16'h0050, 4'h8, 1'b1, 3, 7'h7F, 1'b0});
        vecs.push_back('{16'h0000, 4'h0, 1'b1, 0, 7'h40, 1'b1});
        vecs.push_back('{16'h0000, 4'h0, 1'b1, 1, 7'h7F, 1'b1});
        vecs.push_back('{16'h0000, 4'h0, 1'b1, 2, 7'h7F, 1'b1});
        vecs.push_back('{16'h0000, 4'h0, 1'b1, 3, 7'h7F, 1'b1});
        vecs.push_back('{16'h0000, 4'h0, 1'b0, 3, 7'h40, 1'b1});
        vecs.push_back('{16'h8E0D, 4'h5, 1'b1, 0, 7'h21, 1'b0});
        vecs.push_back('{16'h8E0D, 4'h5, 1'b1, 1, 7'h40, 1'b1});
        vecs.push_back('{16'h8E0D, 4'h5, 1'b1, 2, 7'h06, 1'b0});
        vecs.push_back('{16'h8E0D, 4'h5, 1'b1, 3, 7'h00, 1'b1});

        // Reset state
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_dpn", dp_n, 1);
        chk("rst_fd", frame_done, 0);
        enable = 1'b1;
        rst_n  = 1'b1;
        @(negedge clk);
        chk("rel_an_c1", an, 4'hF);
        @(negedge clk);
        chk("rel_an_c2", an, 4'hE);

        // Scan order, guard cycles and frame period
        do_load(16'h12AF, 4'h0);
        wait_fd("scan_fd_a");
        wait_fd("scan_fd_b");
        for (int k = 0; k < 16; k++) begin
            ea = (k % 4 == 0) ? 4'hF : ~(4'b0001 << (k / 4));
            chk("scan_an", an, ea);
            chk("scan_seg", seg, scan_seg[k / 4]);
            chk("scan_fd", frame_done, (k == 0));
            @(negedge clk);
        end
        chk("scan_period", frame_done, 1);

        // Asynchronous reset while an anode is lit
        wait_an(1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_an", an, 4'hF);
        chk("arst_seg", seg, 7'h7F);
        chk("arst_dpn", dp_n, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_rel_c1", an, 4'hF);
        @(negedge clk);
        chk("arst_rel_c2", an, 4'hE);

        // Table-driven glyph / blanking / decimal point vectors
        foreach (vecs[v]) begin
            lz_en = vecs[v].lz;
            do_load(vecs[v].value, vecs[v].dp);
            wait_fd("vec_fd_a");
            wait_fd("vec_fd_b");
            wait_an(vecs[v].digit);
            chk($sformatf("vec%0d_seg", v), seg, vecs[v].seg);
            chk($sformatf("vec%0d_dpn", v), dp_n, vecs[v].dpn);
        end

        // Mid-frame load must not tear the current frame
        lz_en = 1'b0;
        do_load(16'h1234, 4'h0);
        wait_fd("tear_fd_a");
        wait_fd("tear_fd_b");
        wait_an(2);
        do_load(16'h0000, 4'h0);
        chk("tear_d2_an", an, 4'hB);
        chk("tear_d2_seg", seg, 7'h24);
        wait_an(3);
        chk("tear_d3_seg", seg, 7'h79);
        wait_fd("tear_fd_c");
        for (int d = 0; d < 4; d++) begin
            wait_an(d);
            chk($sformatf("tear_new_d%0d", d), seg, 7'h40);
        end

        // Load coincident with the wrap goes straight to the display
        wait_fd("wl_fd");
        repeat (14) @(negedge clk);
        do_load(16'h5678, 4'h0);
        chk("wl_old_d3", seg, 7'h40);
        @(negedge clk);
        chk("wl_fd_now", frame_done, 1);
        chk("wl_new_d0", seg, 7'h00);
        wait_an(1);
        chk("wl_new_d1", seg, 7'h78);

        // Enable gap: outputs dark, scan keeps running
        do_load(16'h12AF, 4'h2);
        wait_fd("en_fd_a");
        wait_fd("en_fd_b");
        wait_an(1);
        chk("en_dp_lit", dp_n, 0);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("dis_an", an, 4'hF);
            chk("dis_seg", seg, 7'h7F);
            chk("dis_dpn", dp_n, 1);
        end
        enable = 1'b1;
        @(negedge clk);
        chk("reen_an", an, 4'hF);
        chk("reen_seg", seg, 7'h0E);
        chk("reen_fd", frame_done, 1);
        @(negedge clk);
        chk("reen_an_d0", an, 4'hE);
        cnt_p = 1;
        while (frame_done !== 1'b1 && cnt_p < 40) begin
            @(negedge clk);
            cnt_p++;
        end
        chk("reen_period", cnt_p, 16);

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            case ($urandom_range(0, 2))
                0:       value = 16'($urandom);
                1:       value = 16'($urandom) & 16'h00FF;
                default: value = 16'($urandom) & 16'h000F;
            endcase
            dp     = 4'($urandom);
            load   = ($urandom_range(0, 5) == 0);
            lz_en  = 1'($urandom_range(0, 1));
            enable = ($urandom_range(0, 7) != 0);
        end
        @(negedge clk);
        load = 1'b0;
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
